// File: rtl/counter_mod_nbit.sv
// -----------------------------------------------------------------------------
// counter_mod_nbit
//
// Loadable up/down counter with a programmable terminal value. The counter
// runs over 0..limit and either wraps or saturates at the ends of that range.
// Used as the sample/bin address counter and clock-enable divider in the
// spectrum-analyzer datapath, where the frame length need not be a power of
// two.
//
// Parameters
//   WIDTH    counter width in bits (legal range 2..16)
//
// Ports
//   Clk      in   1      rising-edge clock; all state changes on this edge
//   Reset    in   1      synchronous, active-high reset
//   load     in   1      load Din into count (beats inc/dec)
//   inc      in   1      count up by one
//   dec      in   1      count down by one (inc and dec together = hold)
//   Din      in   WIDTH  load value; may exceed limit
//   limit    in   WIDTH  terminal value; sampled every cycle
//   sat_en   in   1      1 = saturate at the range ends, 0 = wrap
//   count    out  WIDTH  registered count
//   md       out  WIDTH  md[k] = AND of count[k:0] (combinational)
//   tc       out  1      count == limit (combinational)
//   wrap     out  1      registered one-cycle pulse per wrap event
//   sat_hit  out  1      sticky flag; a step was blocked by saturation
// -----------------------------------------------------------------------------
module counter_mod_nbit #(
  parameter int WIDTH = 9
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic             inc,
  input  logic             dec,
  input  logic [WIDTH-1:0] Din,
  input  logic [WIDTH-1:0] limit,
  input  logic             sat_en,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] md,
  output logic             tc,
  output logic             wrap,
  output logic             sat_hit
);

  typedef enum logic [1:0] {
    REQ_HOLD,
    REQ_UP,
    REQ_DOWN
  } req_e;

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_sat_hit;

  req_e             w_req;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_wrap_nxt;
  logic             w_sat_hit_nxt;
  logic             w_at_top;
  logic             w_at_bottom;

  // inc and dec together cancel to a hold.
  always_comb begin
    w_req = REQ_HOLD;
    if (inc && !dec) begin
      w_req = REQ_UP;
    end else if (dec && !inc) begin
      w_req = REQ_DOWN;
    end
  end

  // ">=" rather than "==" so a count loaded above limit still wraps/saturates
  // on the next up-step instead of running on to the natural rollover.
  assign w_at_top    = (r_count >= limit);
  assign w_at_bottom = (r_count == '0);

  // Next-state decode. Load sits here; Reset is applied in the register so it
  // overrides everything, including any wrap pulse from this cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned;
    // a missing default here would infer a latch.
    w_count_nxt   = r_count;
    w_wrap_nxt    = 1'b0;
    w_sat_hit_nxt = r_sat_hit;

    if (load) begin
      w_count_nxt   = Din;
      w_sat_hit_nxt = 1'b0;
    end else begin
      unique case (w_req)
        REQ_UP: begin
          if (!w_at_top) begin
            w_count_nxt = r_count + 1'b1;
          end else if (!sat_en) begin
            w_count_nxt = '0;
            w_wrap_nxt  = 1'b1;
          end else begin
            w_sat_hit_nxt = 1'b1;
          end
        end
        REQ_DOWN: begin
          // Any non-zero count (inside or above the range) steps down by one.
          if (!w_at_bottom) begin
            w_count_nxt = r_count - 1'b1;
          end else if (!sat_en) begin
            w_count_nxt = limit;
            w_wrap_nxt  = 1'b1;
          end else begin
            w_sat_hit_nxt = 1'b1;
          end
        end
        default: begin
          w_count_nxt = r_count;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (Reset) begin
      r_count   <= '0;
      r_wrap    <= 1'b0;
      r_sat_hit <= 1'b0;
    end else begin
      r_count   <= w_count_nxt;
      r_wrap    <= w_wrap_nxt;
      r_sat_hit <= w_sat_hit_nxt;
    end
  end

  // md[k] is high when the low k+1 bits are all ones: the divide-by-2^(k+1)
  // enable taps of the binary counter.
  for (genvar k = 0; k < WIDTH; k++) begin : g_md
    assign md[k] = &r_count[k:0];
  end

  assign count   = r_count;
  assign tc      = (r_count == limit);
  assign wrap    = r_wrap;
  assign sat_hit = r_sat_hit;

endmodule
